// File: rtl/ariane_pkg.sv
// Shared branch-prediction types.
package ariane_pkg;
  localparam int unsigned BP_VLEN = cva6_config_pkg::CVA6ConfigXlen;

  typedef struct packed {
    logic               valid;
    logic [BP_VLEN-1:0] ra;
  } ras_t;
endpackage

// File: rtl/cva6_config_pkg.sv
// Core configuration constants shared by the front-end prediction blocks.
package cva6_config_pkg;
  localparam int unsigned CVA6ConfigXlen     = 64;
  localparam int unsigned CVA6ConfigRASDepth = 2;
endpackage

// File: rtl/ras_ckpt.sv
// Return-address stack with a single checkpoint, restored on branch mispredict.
// The snapshot keeps only the TOS entry; deeper entries are assumed untouched until restore.
module ras_ckpt
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = cva6_config_pkg::CVA6ConfigRASDepth,
  parameter int unsigned VLEN  = cva6_config_pkg::CVA6ConfigXlen
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [VLEN-1:0]            data_i,
  input  logic                       ckpt_i,
  input  logic                       restore_i,
  output ras_t                       data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [VLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] snap_tos_q, snap_tos_d;
  logic [CNT_W-1:0] snap_cnt_q, snap_cnt_d;
  logic [VLEN-1:0]  snap_ra_q, snap_ra_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [VLEN-1:0]  wr_data;
  logic [PTR_W-1:0] tos_inc, tos_dec;

  assign tos_inc = (tos_q == PTR_W'(DEPTH - 1)) ? '0 : tos_q + PTR_W'(1);
  assign tos_dec = (tos_q == '0) ? PTR_W'(DEPTH - 1) : tos_q - PTR_W'(1);

  assign data_o.ra    = mem[tos_q];
  assign data_o.valid = (cnt_q != '0);
  assign count_o      = cnt_q;

  // Next-state for pointer, occupancy, snapshot and the single memory write port.
  always_comb begin
    tos_d      = tos_q;
    cnt_d      = cnt_q;
    snap_tos_d = snap_tos_q;
    snap_cnt_d = snap_cnt_q;
    snap_ra_d  = snap_ra_q;
    wr_en      = 1'b0;
    wr_idx     = tos_q;
    wr_data    = data_i;
    if (flush_i) begin
      tos_d      = '0;
      cnt_d      = '0;
      snap_tos_d = '0;
      snap_cnt_d = '0;
      snap_ra_d  = '0;
    end else if (restore_i) begin
      tos_d   = snap_tos_q;
      cnt_d   = snap_cnt_q;
      wr_en   = 1'b1;
      wr_idx  = snap_tos_q;
      wr_data = snap_ra_q;
    end else begin
      if (ckpt_i) begin
        snap_tos_d = tos_q;
        snap_cnt_d = cnt_q;
        snap_ra_d  = mem[tos_q];
      end else begin
        snap_tos_d = snap_tos_q;
      end
      case ({push_i, pop_i})
        2'b10: begin
          tos_d  = tos_inc;
          wr_en  = 1'b1;
          wr_idx = tos_inc;
          cnt_d  = (cnt_q == CNT_W'(DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
        end
        2'b01: begin
          if (cnt_q != '0) begin
            tos_d = tos_dec;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            tos_d = tos_q;
          end
        end
        2'b11: begin
          // Replacing the TOS on an empty stack must still grow it.
          if (cnt_q == '0) begin
            tos_d  = tos_inc;
            wr_en  = 1'b1;
            wr_idx = tos_inc;
            cnt_d  = CNT_W'(1);
          end else begin
            wr_en  = 1'b1;
            wr_idx = tos_q;
          end
        end
        default: begin
          tos_d = tos_q;
        end
      endcase
    end
  end

  // Control and snapshot registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tos_q      <= '0;
      cnt_q      <= '0;
      snap_tos_q <= '0;
      snap_cnt_q <= '0;
      snap_ra_q  <= '0;
    end else begin
      tos_q      <= tos_d;
      cnt_q      <= cnt_d;
      snap_tos_q <= snap_tos_d;
      snap_cnt_q <= snap_cnt_d;
      snap_ra_q  <= snap_ra_d;
    end
  end

  // Entry storage; contents are don't-care after reset, so no reset value.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed table-driven bench for ras_ckpt at the default DEPTH=2, VLEN=64.
module tb_ras_ckpt;
  import ariane_pkg::*;

  localparam int unsigned DEPTH = cva6_config_pkg::CVA6ConfigRASDepth;
  localparam int unsigned VLEN  = cva6_config_pkg::CVA6ConfigXlen;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct {
    logic            rst;
    logic            flush;
    logic            push;
    logic            pop;
    logic            ckpt;
    logic            restore;
    logic [63:0]     data;
    logic            exp_valid;
    logic [63:0]     exp_ra;
    int              exp_cnt;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             push;
  logic             pop;
  logic [VLEN-1:0]  data;
  logic             ckpt;
  logic             restore;
  ras_t             data_o;
  logic [CNT_W-1:0] count_o;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  ras_ckpt dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .flush_i  (flush),
    .push_i   (push),
    .pop_i    (pop),
    .data_i   (data),
    .ckpt_i   (ckpt),
    .restore_i(restore),
    .data_o   (data_o),
    .count_o  (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic pu, input logic po,
                      input logic ck, input logic re, input logic [63:0] d);
    rst = r; flush = f; push = pu; pop = po; ckpt = ck; restore = re; data = d;
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; ckpt = 1'b0; restore = 1'b0;
  endtask

  task automatic expect_state(input string name, input int idx, input logic v, input logic [63:0] ra, input int cnt);
    chk({name, ".valid"}, idx, 64'(data_o.valid), 64'(v));
    chk({name, ".count"}, idx, 64'(count_o), 64'(cnt));
    if (v) begin
      chk({name, ".ra"}, idx, 64'(data_o.ra), ra);
    end else begin
      checks = checks;
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; ckpt = 1'b0; restore = 1'b0; data = '0;

    //             rst   flush push  pop   ckpt  rest  data         v     ra           cnt
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,     1'b0, 64'h0,     0}); // 0 reset
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1000,  1'b1, 64'h1000,  1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h2000,  1'b1, 64'h2000,  2});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,     1'b1, 64'h1000,  1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,     1'b0, 64'h0,     0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,     1'b0, 64'h0,     0}); // 5 pop empty
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'hA,     1'b1, 64'hA,     1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'hB,     1'b1, 64'hB,     2});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'hC,     1'b1, 64'hC,     2}); // 8 wrap
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,     1'b1, 64'hB,     1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,     1'b0, 64'h0,     0}); // 10 A lost
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1000,  1'b1, 64'h1000,  1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h3000,  1'b1, 64'h3000,  1}); // 12 replace
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,     1'b0, 64'h0,     0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h5000,  1'b1, 64'h5000,  1}); // 14 push+pop empty
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,     1'b0, 64'h0,     0}); // 15 flush
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1000,  1'b1, 64'h1000,  1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,     1'b1, 64'h1000,  1}); // 17 ckpt
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,     1'b0, 64'h0,     0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h4000,  1'b1, 64'h4000,  1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0,     1'b1, 64'h1000,  1}); // 20 restore
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h7000,  1'b1, 64'h1000,  1}); // 21 push ignored
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h6000,  1'b1, 64'h6000,  2});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0,     1'b0, 64'h0,     0}); // 23 flush wins
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0,     1'b0, 64'h0,     0}); // 24 empty snapshot
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1111,  1'b1, 64'h1111,  1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h2222,  1'b1, 64'h2222,  2}); // 26 ckpt+push
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h3333,  1'b1, 64'h3333,  2}); // 27 clobbers 0x1111
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0,     1'b1, 64'h1111,  1}); // 28 TOS reloaded
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h4444,  1'b1, 64'h4444,  2});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,     1'b1, 64'h4444,  2}); // 30 ckpt pending
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h9999,  1'b0, 64'h0,     0}); // 31 reset wins
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0,     1'b0, 64'h0,     0}); // 32 restore empty
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h8888,  1'b1, 64'h8888,  1});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].flush, vecs[i].push, vecs[i].pop,
           vecs[i].ckpt, vecs[i].restore, vecs[i].data);
      expect_state("vec", i, vecs[i].exp_valid, vecs[i].exp_ra, vecs[i].exp_cnt);
    end

    // Long push run: occupancy saturates at DEPTH, TOS always the newest push.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'hF000 + 64'(i));
      expect_state("fill", i, 1'b1, 64'hF000 + 64'(i), (i + 1 < int'(DEPTH)) ? i + 1 : int'(DEPTH));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    expect_state("drain", 0, 1'b1, 64'hF004, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    expect_state("drain", 1, 1'b0, 64'h0, 0);

    // Reset asserted together with every other control input.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'hABCD);
    expect_state("pre_rst", 0, 1'b1, 64'hABCD, 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h5555);
    expect_state("rst_all", 0, 1'b0, 64'h0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    expect_state("rst_all", 1, 1'b0, 64'h0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'hBEEF);
    expect_state("rst_all", 2, 1'b1, 64'hBEEF, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ras_ckpt.md
RAS_CKPT -- requirements
Module: ras_ckpt

Interface
REQ-001 SHALL have parameter DEPTH, default cva6_config_pkg::CVA6ConfigRASDepth (2); number of return-address entries, legal range 2..16.
REQ-002 SHALL have parameter VLEN, default cva6_config_pkg::CVA6ConfigXlen (64); width of a return address.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port flush_i, input, 1, empties the stack.
REQ-006 SHALL have port push_i, input, 1, call predicted; push data_i.
REQ-007 SHALL have port pop_i, input, 1, return predicted; pop TOS.
REQ-008 SHALL have port data_i, input, VLEN, return address to push.
REQ-009 SHALL have port ckpt_i, input, 1, snapshot current state; branch predicted.
REQ-010 SHALL have port restore_i, input, 1, mispredict; reload the snapshot.
REQ-011 SHALL have port data_o, output, ras_t, {valid, ra[VLEN-1:0]}; TOS entry, valid=0 when empty.
REQ-012 SHALL have port count_o, output, $clog2(DEPTH+1), occupied entries.

Function
REQ-013 Storage: circular array of DEPTH entries, TOS pointer tos_q (mod DEPTH), occupancy cnt_q (0..DEPTH).
REQ-014 data_o: combinational from registered state only; data_o.ra=mem[tos_q], data_o.valid=(cnt_q!=0); no input-to-output path.
REQ-015 Push alone: tos_q+1 mod DEPTH, write data_i there, cnt_q=min(cnt_q+1, DEPTH); visible on data_o next cycle.
REQ-016 Push when full: oldest entry overwritten (wrap-around), cnt_q stays DEPTH.
REQ-017 Pop alone, cnt_q>0: tos_q-1 mod DEPTH, cnt_q-1; entry contents untouched.
REQ-018 Pop when empty: no state change.
REQ-019 Push and pop together: mem[tos_q]=data_i, tos_q and cnt_q unchanged; when empty, behaves as push alone.
REQ-020 Checkpoint: ckpt_i loads snapshot {tos_q, cnt_q, mem[tos_q]} as seen before this cycle's push/pop; push/pop that cycle still execute.
REQ-021 Restore: tos_q, cnt_q and mem[snap_tos] reloaded from snapshot next cycle; push/pop/ckpt_i that cycle are ignored.
REQ-022 Restore with no checkpoint taken since reset/flush: restores to empty (snapshot reset value cnt=0).
REQ-023 Priority, highest first: rst_i, flush_i, restore_i, ckpt_i plus push/pop.
REQ-024 flush_i: cnt_q=0, tos_q=0, snapshot cleared to empty; mem contents need not be cleared.
REQ-025 Only one snapshot held; a new ckpt_i overwrites the previous one.

Reset
REQ-026 On rst_i high at a clock edge: tos_q=0, cnt_q=0, snapshot={0,0,0}, data_o.valid=0, count_o=0; mem contents don't-care.
REQ-027 rst_i overrides any concurrent push/pop/ckpt/restore/flush; first post-reset operation accepted the cycle rst_i is low.

Structure
REQ-028 ras_t {logic valid; logic [VLEN-1:0] ra;} SHALL live in the shared ariane_pkg next to other branch-prediction types; DEPTH and VLEN come from cva6_config_pkg.
REQ-029 Single flat module; no sub-module; no SRAM macro (flops only at DEPTH<=16).

Verification
REQ-030 Reset then push 0x1000, 0x2000 -> data_o={1,0x2000}, count_o=2; pop -> {1,0x1000}, count_o=1.
REQ-031 DEPTH=2: push A,B,C -> count_o=2, TOS=C; pop -> TOS=B; pop -> valid=0 (A lost to wrap).
REQ-032 Empty stack, pop -> no change, count_o=0; push+pop same cycle of 0x3000 when TOS=0x1000, count 1 -> TOS=0x3000, count 1.
REQ-033 Push 0x1000, ckpt, pop, push 0x4000, restore -> next cycle TOS=0x1000, count_o=1.
REQ-034 Restore and push same cycle -> push ignored; flush and restore same cycle -> empty.
REQ-035 rst_i mid-sequence with count_o=2 and pending ckpt -> next cycle count_o=0, valid=0; subsequent restore yields empty.
